// File: rtl/life_engine.sv
// Game-of-Life core: parametrised board, programmable B/S rules, selectable edge mode,
// one-cell-per-cycle update into a shadow board that is committed only when commit_ok allows.
module life_engine #(
  parameter int          LOG_W           = 6,
  parameter int          LOG_H           = 5,
  parameter int          UPDATE_INTERVAL = 2400000,
  parameter logic [15:0] SEED            = 16'h0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   step,
  input  logic                   randomize,
  input  logic                   clear,
  input  logic [8:0]             birth_mask,
  input  logic [8:0]             survive_mask,
  input  logic                   wrap,
  input  logic                   commit_ok,
  input  logic [LOG_W+LOG_H-1:0] rd_addr,
  output logic                   rd_data,
  output logic                   busy,
  output logic                   gen_done,
  output logic [15:0]            generation,
  output logic [LOG_W+LOG_H:0]   population
);
  localparam int N  = 1 << (LOG_W + LOG_H);
  localparam int AW = LOG_W + LOG_H;
  localparam int PW = AW + 1;
  localparam int TW = $clog2(UPDATE_INTERVAL);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {S_IDLE, S_RAND, S_UPDATE, S_WAIT} state_e;

  state_e          state_q;
  logic [N-1:0]    cur_q, nxt_q;
  logic [AW-1:0]   idx_q;
  logic [PW-1:0]   pop_acc_q, population_q;
  logic [15:0]     generation_q, lfsr_q, lfsr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [8:0]      bmask_q, smask_q;
  logic            wrap_q, gen_done_q, rd_data_q;

  logic [LOG_W-1:0] cx, nx_c;
  logic [LOG_H-1:0] cy, ny_c;
  logic             off_c, trig_d, new_d;
  logic [3:0]       cnt_d;

  assign cx = idx_q[LOG_W-1:0];
  assign cy = idx_q[AW-1:LOG_W];
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign trig_d = step || (run && timer_q == TW'(UPDATE_INTERVAL - 1));

  // Neighbour sum; coordinates wrap naturally in LOG_W/LOG_H bits, dead border masks the wrapped taps.
  always_comb begin
    cnt_d = '0;
    nx_c  = '0;
    ny_c  = '0;
    off_c = 1'b0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx_c  = cx + LOG_W'(dx);
        ny_c  = cy + LOG_H'(dy);
        off_c = (dx < 0 && cx == '0) || (dx > 0 && cx == '1) ||
                (dy < 0 && cy == '0) || (dy > 0 && cy == '1);
        if (!(dx == 0 && dy == 0) && (wrap_q || !off_c))
          cnt_d = cnt_d + 4'(cur_q[{ny_c, nx_c}]);
      end
    end
  end

  assign new_d = cur_q[idx_q] ? smask_q[cnt_d] : bmask_q[cnt_d];

  always_comb begin
    timer_d = timer_q;
    if (state_q == S_IDLE) begin
      if (trig_d)   timer_d = '0;
      else if (run) timer_d = timer_q + TW'(1);
    end
  end

  // Board storage is not reset: RAND rewrites every cell after reset anyway.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE:   if (clear) cur_q <= '0;
      S_RAND:   cur_q[idx_q] <= lfsr_q[0];
      S_UPDATE: nxt_q[idx_q] <= new_d;
      S_WAIT:   if (commit_ok) cur_q <= nxt_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RAND;
      idx_q        <= '0;
      pop_acc_q    <= '0;
      population_q <= '0;
      generation_q <= '0;
      timer_q      <= '0;
      lfsr_q       <= SEED_EFF;
      bmask_q      <= '0;
      smask_q      <= '0;
      wrap_q       <= 1'b0;
      gen_done_q   <= 1'b0;
      rd_data_q    <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      timer_q    <= timer_d;
      gen_done_q <= 1'b0;
      rd_data_q  <= cur_q[rd_addr];
      case (state_q)
        S_IDLE: begin
          if (clear) begin
            population_q <= '0;
            generation_q <= '0;
          end else if (randomize) begin
            idx_q     <= '0;
            pop_acc_q <= '0;
            state_q   <= S_RAND;
          end else if (trig_d) begin
            bmask_q   <= birth_mask;
            smask_q   <= survive_mask;
            wrap_q    <= wrap;
            idx_q     <= '0;
            pop_acc_q <= '0;
            state_q   <= S_UPDATE;
          end
        end
        S_RAND: begin
          pop_acc_q <= pop_acc_q + PW'(lfsr_q[0]);
          idx_q     <= idx_q + AW'(1);
          if (idx_q == '1) begin
            population_q <= pop_acc_q + PW'(lfsr_q[0]);
            generation_q <= '0;
            state_q      <= S_IDLE;
          end
        end
        S_UPDATE: begin
          pop_acc_q <= pop_acc_q + PW'(new_d);
          idx_q     <= idx_q + AW'(1);
          if (idx_q == '1) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (commit_ok) begin
            population_q <= pop_acc_q;
            generation_q <= generation_q + 16'd1;
            gen_done_q   <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data    = rd_data_q;
  assign busy       = (state_q != S_IDLE);
  assign gen_done   = gen_done_q;
  assign generation = generation_q;
  assign population = population_q;
endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: table-driven pattern steps, random-rule steps against a
// coordinate-level Life model, commit gating, auto-run spacing and reset behaviour.
module tb_life_engine;
  localparam int LW = 6, LH = 5;
  localparam int W = 1 << LW, H = 1 << LH, N = W * H, AW = LW + LH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, run, step, randomize, clear, wrap, commit_ok;
  logic [8:0]    bm, sm;
  logic [AW-1:0] rd_addr;
  logic          rd_data, busy, gen_done;
  logic [15:0]   generation;
  logic [AW:0]   population;

  life_engine dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .randomize(randomize), .clear(clear),
    .birth_mask(bm), .survive_mask(sm), .wrap(wrap), .commit_ok(commit_ok),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .gen_done(gen_done),
    .generation(generation), .population(population)
  );

  // Small board used for auto-run timing
  logic        s_run, s_rd_data, s_busy, s_gen_done;
  logic [15:0] s_generation;
  logic [6:0]  s_population;
  life_engine #(.LOG_W(3), .LOG_H(3), .UPDATE_INTERVAL(100)) dut_s (
    .clk(clk), .rst_n(rst_n), .run(s_run), .step(1'b0), .randomize(1'b0), .clear(1'b0),
    .birth_mask(9'h008), .survive_mask(9'h00C), .wrap(1'b1), .commit_ok(1'b1),
    .rd_addr(6'd0), .rd_data(s_rd_data), .busy(s_busy), .gen_done(s_gen_done),
    .generation(s_generation), .population(s_population)
  );

  int errors = 0, checks = 0;
  bit [N-1:0] rb, mb, nb, seedb, eb;
  logic [N-1:0] force_board;

  typedef struct packed {
    logic [2:0][5:0] ix;
    logic [2:0][4:0] iy;
    logic            wr;
    logic [1:0]      n_out;
    logic [2:0][5:0] ox;
    logic [2:0][4:0] oy;
    logic [11:0]     pop;
  } vec_t;
  vec_t vt [4];

  task automatic check(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit [N-1:0] next_gen(bit [N-1:0] b, bit [8:0] bmk, bit [8:0] smk, bit wr);
    bit [N-1:0] r;
    int c, nx, ny;
    r = '0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        c = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            nx = x + dx;
            ny = y + dy;
            if (wr) begin
              nx = (nx + W) % W;
              ny = (ny + H) % H;
            end else if (nx < 0 || nx >= W || ny < 0 || ny >= H) continue;
            c += int'(b[ny*W + nx]);
          end
        r[y*W + x] = b[y*W + x] ? smk[c] : bmk[c];
      end
    return r;
  endfunction

  function automatic bit [N-1:0] seed_board();
    bit [N-1:0] r;
    int l;
    l = 1;
    for (int i = 0; i < N; i++) begin
      r[i] = l[0];
      l = ((l << 1) | (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1)) & 16'hFFFF;
    end
    return r;
  endfunction

  task automatic read_board();
    rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      rb[i] = rd_data;
      if (i < N - 1) rd_addr = AW'(i + 1);
    end
  endtask

  task automatic cmp_board(string nm, bit [N-1:0] exp);
    int bad;
    read_board();
    bad = 0;
    for (int i = 0; i < N; i++) if (rb[i] !== exp[i]) bad++;
    check(nm, bad, 0);
  endtask

  task automatic wait_idle(string nm, int max);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < max);
    check(nm, busy, 0);
  endtask

  task automatic wait_done(string nm, int max);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!gen_done && n < max);
    check(nm, gen_done, 1);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    int n, a;
    // {pattern, wrap, expected live cells, population}
    vt[0] = '{ix:{6'd12,6'd11,6'd10}, iy:{5'd5,5'd5,5'd5}, wr:1'b0, n_out:2'd3,
              ox:{6'd11,6'd11,6'd11}, oy:{5'd6,5'd5,5'd4}, pop:12'd3};
    vt[1] = '{ix:{6'd2,6'd1,6'd0}, iy:{5'd0,5'd0,5'd0}, wr:1'b0, n_out:2'd2,
              ox:{6'd0,6'd1,6'd1}, oy:{5'd0,5'd1,5'd0}, pop:12'd2};
    vt[2] = '{ix:{6'd2,6'd1,6'd0}, iy:{5'd0,5'd0,5'd0}, wr:1'b1, n_out:2'd3,
              ox:{6'd1,6'd1,6'd1}, oy:{5'd31,5'd1,5'd0}, pop:12'd3};
    vt[3] = '{ix:{6'd0,6'd63,6'd62}, iy:{5'd31,5'd31,5'd31}, wr:1'b1, n_out:2'd3,
              ox:{6'd63,6'd63,6'd63}, oy:{5'd0,5'd31,5'd30}, pop:12'd3};

    rst_n = 1'b0; run = 1'b0; step = 1'b0; randomize = 1'b0; clear = 1'b0;
    wrap = 1'b0; commit_ok = 1'b1; bm = 9'h008; sm = 9'h00C; rd_addr = '0;
    s_run = 1'b0; force_board = '0;
    seedb = seed_board();

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_rd_data", rd_data, 0);
    check("rst_gen_done", gen_done, 0);
    check("rst_generation", generation, 0);
    check("rst_population", population, 0);
    rst_n = 1'b1;

    // Auto-run spacing on the 8x8 board: 100 IDLE + 64 UPDATE + 1 WAIT
    s_run = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_gen_done && n < 1000);
    check("run_first_done", s_gen_done, 1);
    check("run_gen1", s_generation, 1);
    for (int k = 2; k <= 3; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!s_gen_done && n < 400);
      check("run_spacing", n, 165);
      check("run_gen", s_generation, k);
    end
    s_run = 1'b0;

    // Post-reset board is the LFSR pattern
    wait_idle("rand_idle", 3000);
    check("rand_generation", generation, 0);
    check("rand_population", population, $countones(seedb));
    cmp_board("rand_board", seedb);

    // Random rules against the model, starting from the seed board
    mb = seedb;
    for (int k = 1; k <= 3; k++) begin
      bm = 9'($urandom_range(0, 511));
      sm = 9'($urandom_range(0, 511));
      wrap = 1'($urandom_range(0, 1));
      nb = next_gen(mb, bm, sm, wrap);
      pulse_step();
      wait_done("rnd_done", 5000);
      check("rnd_generation", generation, k);
      check("rnd_population", population, $countones(nb));
      cmp_board("rnd_board", nb);
      mb = nb;
    end

    bm = 9'h000; sm = 9'h000;
    pulse_step();
    wait_done("zero_done", 5000);
    check("zero_population", population, 0);
    check("zero_generation", generation, 4);
    bm = 9'h008; sm = 9'h00C;

    // Table-driven pattern steps
    for (int v = 0; v < 4; v++) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_population", population, 0);
      check("clr_generation", generation, 0);
      force_board = '0;
      eb = '0;
      for (int j = 0; j < 3; j++) force_board[int'(vt[v].iy[j])*W + int'(vt[v].ix[j])] = 1'b1;
      for (int j = 0; j < int'(vt[v].n_out); j++) eb[int'(vt[v].oy[j])*W + int'(vt[v].ox[j])] = 1'b1;
      force dut.cur_q = force_board;
      @(negedge clk);
      release dut.cur_q;
      wrap = vt[v].wr;
      pulse_step();
      wait_done("tbl_done", 5000);
      check("tbl_generation", generation, 1);
      check("tbl_population", population, vt[v].pop);
      @(negedge clk);
      check("tbl_done_pulse", gen_done, 0);
      cmp_board("tbl_board", eb);
      check("tbl_model", int'(next_gen(force_board, bm, sm, wrap) != eb), 0);
      mb = eb;
    end

    // Commit held off by commit_ok; commands during busy are dropped
    nb = next_gen(mb, bm, sm, wrap);
    a = 0;
    for (int i = N - 1; i >= 0; i--) if (mb[i] != nb[i]) a = i;
    commit_ok = 1'b0;
    pulse_step();
    repeat (50) @(negedge clk);
    step = 1'b1; randomize = 1'b1;
    @(negedge clk);
    step = 1'b0; randomize = 1'b0;
    repeat (2048 + 5000) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    rd_addr = AW'(a);
    repeat (2) @(negedge clk);
    check("hold_busy", busy, 1);
    check("hold_generation", generation, 1);
    check("hold_rd_data", rd_data, mb[a]);
    check("hold_gen_done", gen_done, 0);
    commit_ok = 1'b1;
    @(negedge clk);
    check("commit_gen_done", gen_done, 1);
    check("commit_generation", generation, 2);
    check("commit_rd_old", rd_data, mb[a]);
    @(negedge clk);
    check("commit_rd_new", rd_data, nb[a]);
    check("commit_done_pulse", gen_done, 0);
    check("commit_not_queued", busy, 0);
    check("commit_population", population, $countones(nb));
    cmp_board("commit_board", nb);

    randomize = 1'b1;
    @(negedge clk);
    randomize = 1'b0;
    check("rnd_cmd_busy", busy, 1);
    wait_idle("rnd_cmd_idle", 3000);
    check("rnd_cmd_generation", generation, 0);

    // Reset in the middle of UPDATE
    pulse_step();
    repeat (100) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_generation", generation, 0);
    check("mid_rst_population", population, 0);
    check("mid_rst_gen_done", gen_done, 0);
    check("mid_rst_busy", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_idle("mid_rand_idle", 3000);
    check("mid_population", population, $countones(seedb));
    cmp_board("mid_board", seedb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
